// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative multiply/divide unit that owns the HI/LO pair.
// Runs one bit per cycle beside the single-cycle ALU. Md_busy lets the hazard
// logic hold issue until HI/LO are final.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; accepts mult/multu/div/divu and mthi/mtlo
// CALC  | one shift-add (multiply) or restoring-divide step per cycle
// FIX   | sign correction, HI/LO write, Md_done pulse on the next cycle
module multdiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            Md_start,
    input  logic [5:0]      Function_opcode,
    input  logic [XLEN-1:0] Read_data_1,
    input  logic [XLEN-1:0] Read_data_2,
    output logic            Md_busy,
    output logic            Md_done,
    output logic            Md_div_zero,
    output logic [XLEN-1:0] Md_Result,
    output logic [XLEN-1:0] Hi_out,
    output logic [XLEN-1:0] Lo_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    state_t state_q, state_d;

    logic [XLEN-1:0] hi_q, lo_q;
    logic [XLEN-1:0] acc_hi, acc_lo;   // product {hi,lo} or {remainder, dividend/quotient}
    logic [XLEN-1:0] opb;              // multiplicand or divisor magnitude
    logic [4:0]      iter_cnt;
    logic            op_div, neg_main, neg_rem, div_zero;
    logic            done_q, dz_q;

    logic            is_md, is_signed, is_div, b_zero;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign is_md     = (Function_opcode == FN_MULT) || (Function_opcode == FN_MULTU) ||
                       (Function_opcode == FN_DIV)  || (Function_opcode == FN_DIVU);
    // Low bit clear selects the signed flavour of both mult and div.
    assign is_signed = ~Function_opcode[0];
    assign is_div    = Function_opcode[1];
    assign b_zero    = (Read_data_2 == '0);

    // Magnitude of 0x80000000 is 2^31, which still fits as an unsigned word.
    assign mag_a = (is_signed && Read_data_1[XLEN-1]) ? (~Read_data_1 + 1'b1) : Read_data_1;
    assign mag_b = (is_signed && Read_data_2[XLEN-1]) ? (~Read_data_2 + 1'b1) : Read_data_2;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    // Remainder stays below the divisor, so bit XLEN of the trial is a clean borrow flag.
    assign div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb};
    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_main ? (~prod + 1'b1) : prod;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a zero divisor skips the iterations entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Md_start && is_md) state_d = (is_div && b_zero) ? FIX : CALC;
            CALC: if (iter_cnt == 5'd31) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration, final sign fix and HI/LO write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            iter_cnt <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Md_start && is_md) begin
                        op_div   <= is_div;
                        opb      <= mag_b;
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        iter_cnt <= '0;
                        neg_main <= is_signed && (Read_data_1[XLEN-1] ^ Read_data_2[XLEN-1]);
                        neg_rem  <= is_signed && Read_data_1[XLEN-1];
                        div_zero <= is_div && b_zero;
                    end else if (Md_start && Function_opcode == FN_MTHI) begin
                        hi_q <= Read_data_1;
                    end else if (Md_start && Function_opcode == FN_MTLO) begin
                        lo_q <= Read_data_1;
                    end
                end
                CALC: begin
                    iter_cnt <= iter_cnt + 5'd1;
                    if (op_div) begin
                        if (!div_trial[XLEN]) begin
                            acc_hi <= div_trial[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    dz_q   <= div_zero;
                    if (!div_zero) begin
                        if (op_div) begin
                            lo_q <= neg_main ? (~acc_lo + 1'b1) : acc_lo;
                            hi_q <= neg_rem  ? (~acc_hi + 1'b1) : acc_hi;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // mfhi/mflo read path; only meaningful while not busy.
    always_comb begin
        Md_Result = '0;
        case (Function_opcode)
            FN_MFHI: Md_Result = hi_q;
            FN_MFLO: Md_Result = lo_q;
            default: Md_Result = '0;
        endcase
    end

    assign Md_busy     = (state_q != IDLE);
    assign Md_done     = done_q;
    assign Md_div_zero = dz_q;
    assign Hi_out      = hi_q;
    assign Lo_out      = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Md_start;
    logic [5:0]  Function_opcode;
    logic [31:0] Read_data_1, Read_data_2;
    logic        Md_busy, Md_done, Md_div_zero;
    logic [31:0] Md_Result, Hi_out, Lo_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    multdiv_sequencer #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .Md_start(Md_start),
        .Function_opcode(Function_opcode), .Read_data_1(Read_data_1),
        .Read_data_2(Read_data_2), .Md_busy(Md_busy), .Md_done(Md_done),
        .Md_div_zero(Md_div_zero), .Md_Result(Md_Result),
        .Hi_out(Hi_out), .Lo_out(Lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        logic [63:0] ea = {32'h0, a};
        logic [63:0] eb = {32'h0, b};
        logic [63:0] q, r, p;
        md_model = '0;
        case (fn)
            6'h18: begin p = sa * sb; md_model = {1'b0, p}; end
            6'h19: begin p = ea * eb; md_model = {1'b0, p}; end
            6'h1A: if (b == 0) md_model = {1'b1, 64'h0};
                   else begin q = sa / sb; r = sa % sb; md_model = {1'b0, r[31:0], q[31:0]}; end
            6'h1B: if (b == 0) md_model = {1'b1, 64'h0};
                   else md_model = {1'b0, a % b, a / b};
            default: md_model = '0;
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          m_left = 0;
    logic [64:0] m_res;

    // Model: an op occupies 33 cycles (1 for divide-by-zero), results land with done.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_dz   <= p_dz;
                    if (!p_dz) begin m_hi <= p_hi; m_lo <= p_lo; end
                end
            end else if (Md_start) begin
                case (Function_opcode)
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        m_res = md_model(Function_opcode, Read_data_1, Read_data_2);
                        p_dz   <= m_res[64];
                        p_hi   <= m_res[63:32];
                        p_lo   <= m_res[31:0];
                        m_left <= m_res[64] ? 1 : 33;
                    end
                    6'h11: m_hi <= Read_data_1;
                    6'h13: m_lo <= Read_data_1;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy",   Md_busy,     m_left != 0);
            chk("done",   Md_done,     m_done);
            chk("dzero",  Md_div_zero, m_dz);
            chk("hi",     Hi_out,      m_hi);
            chk("lo",     Lo_out,      m_lo);
            chk("result", Md_Result,   (Function_opcode == 6'h10) ? m_hi :
                                       (Function_opcode == 6'h12) ? m_lo : 32'h0);
        end
    end

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #2;
        Md_start = 1'b1; Function_opcode = fn; Read_data_1 = a; Read_data_2 = b;
        @(posedge clock); #2;
        Md_start = 1'b0; Function_opcode = 6'h00; Read_data_1 = '0; Read_data_2 = '0;
    endtask

    task automatic wait_done(output int nbusy, output logic saw_dz);
        bit seen = 1'b0;
        nbusy = 0; saw_dz = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (Md_done) begin seen = 1'b1; saw_dz = Md_div_zero; end
            else if (Md_busy) nbusy++;
        end
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy, input logic exp_dz);
        int   nb;
        logic dz;
        issue(fn, a, b);
        wait_done(nb, dz);
        chk({name, "_busycyc"}, nb, exp_busy);
        chk({name, "_dz"}, dz, exp_dz);
        chk({name, "_hi"}, Hi_out, exp_hi);
        chk({name, "_lo"}, Lo_out, exp_lo);
        chk({name, "_model_hi"}, m_hi, exp_hi);
        chk({name, "_model_lo"}, m_lo, exp_lo);
    endtask

    initial begin
        int   nb;
        logic dz;
        bit   done_after_reset;
        reset_n = 1'b1; Md_start = 1'b0; Function_opcode = 6'h00;
        Read_data_1 = '0; Read_data_2 = '0;
        #1 reset_n = 1'b0;
        #2 chk_en = 1'b1;
        chk("rst_hi", Hi_out, 32'h0);
        chk("rst_lo", Lo_out, 32'h0);
        chk("rst_busy", Md_busy, 1'b0);
        chk("rst_done", Md_done, 1'b0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
        run_op("mult_neg",  6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b0);
        Function_opcode = 6'h12;
        @(negedge clock); chk("mflo", Md_Result, 32'hFFFFFFF1);
        Function_opcode = 6'h10;
        @(negedge clock); chk("mfhi", Md_Result, 32'hFFFFFFFF);
        Function_opcode = 6'h00;

        run_op("mult_nn",   6'h18, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 33, 1'b0);
        run_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        run_op("div_negb",  6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0);
        run_op("divu",      6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33, 1'b0);
        run_op("div_ovf",   6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);

        issue(6'h11, 32'h00001234, 32'h0);
        issue(6'h13, 32'h00005678, 32'h0);
        @(negedge clock);
        chk("mthi", Hi_out, 32'h00001234);
        chk("mtlo", Lo_out, 32'h00005678);
        run_op("divu_zero", 6'h1B, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00005678, 1, 1'b1);

        issue(6'h20, 32'hDEADBEEF, 32'h1);
        @(negedge clock);
        chk("noop_busy", Md_busy, 1'b0);
        chk("noop_hi", Hi_out, 32'h00001234);

        // Writes and new ops issued mid-operation must be dropped.
        issue(6'h18, 32'h12345678, 32'h00000100);
        repeat (8) @(posedge clock);
        issue(6'h11, 32'h0000AAAA, 32'h0);
        issue(6'h1B, 32'h00000009, 32'h00000003);
        wait_done(nb, dz);
        chk("busy_ign_hi", Hi_out, 32'h00000012);
        chk("busy_ign_lo", Lo_out, 32'h34567800);
        repeat (3) @(negedge clock);
        chk("busy_ign_idle", Md_busy, 1'b0);

        // Reset in the middle of an operation.
        issue(6'h19, 32'hFFFFFFFF, 32'h00000003);
        repeat (19) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", Md_busy, 1'b0);
        chk("midrst_hi", Hi_out, 32'h0);
        chk("midrst_lo", Lo_out, 32'h0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        done_after_reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (Md_done) done_after_reset = 1'b1;
        end
        chk("midrst_nodone", done_after_reset, 1'b0);
        chk("midrst_hi_end", Hi_out, 32'h0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Iterative multiply/divide unit and HI/LO register owner for the Minisys 32-bit datapath. It sequences mult, multu, div and divu over 32 one-bit-per-cycle iterations beside the single-cycle ALU, and serves mfhi, mflo, mthi and mtlo. It raises Md_busy so the hazard logic stalls issue until HI/LO are valid.

Parameters:
XLEN, 32, operand width; iteration count equals XLEN (only 32 is supported).

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
Md_start  input  1  a valid multdiv-class R-type instruction is in EX this cycle
Function_opcode  input  6  instruction[5:0]: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
Read_data_1  input  32  rs value (dividend, multiplicand, or mthi/mtlo source)
Read_data_2  input  32  rt value (divisor or multiplier)
Md_busy  output  1  high whenever state != IDLE
Md_done  output  1  one-cycle pulse; HI/LO are final
Md_div_zero  output  1  one-cycle pulse with Md_done when the divisor was 0
Md_Result  output  32  HI for mfhi, LO for mflo, else 0 (combinational)
Hi_out  output  32  current HI register
Lo_out  output  32  current LO register

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, HI=LO=0, iteration counter=0, internal accumulators=0, Md_done=Md_div_zero=0. Reset during CALC or FIX abandons the operation, and HI/LO read 0.
- States: IDLE, CALC, FIX.
- IDLE plus Md_start plus mult/multu/div/divu, at edge E0:
  - Latch magnitudes. Signed ops take the absolute value; for 0x80000000 the magnitude is 2^31, held as 32-bit unsigned.
  - Record result signs. Product and quotient are negative iff operand signs differ (signed ops only). Remainder takes the sign of the dividend.
  - counter=0, state=CALC.
- Divide with Read_data_2==0 at E0: state goes directly to FIX with a div-zero flag set. No CALC cycles.
- CALC: one iteration per edge, counter increments. After the edge where counter reaches 31 (E32), state=FIX.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring; shift remainder left, bring in the next dividend bit, subtract if no borrow, set the quotient bit.
- FIX, one edge (E33), then state=IDLE:
  - Apply two's-complement negation where required, modulo 2^32 or 2^64.
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
  - Div-by-zero: HI/LO unchanged.
  - Md_done=1 (and Md_div_zero if flagged) for the cycle following E33.
- Latency: Md_busy is high from after E0 through E33, i.e. 33 cycles (1 cycle for div-by-zero). HI/LO are visible the cycle after E33.
- mthi/mtlo in IDLE with Md_start: HI or LO = Read_data_1 at that edge; no busy, no done.
- mfhi/mflo: Md_Result is combinational from current HI/LO. The value is valid only when Md_busy=0; the stall is upstream's duty.
- Any Md_start while Md_busy=1 is ignored, including mthi/mtlo and a new op. HI/LO and the in-flight operation are unaffected.
- Overflow case 0x80000000 div 0xFFFFFFFF (signed): LO=0x80000000, HI=0, no flag.
- Md_start with any other function code: no effect.

Test Plan:
- Reset, then multu 0xFFFFFFFF × 0xFFFFFFFF -> Md_busy high 33 cycles; Md_done 34 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001.
- mult 0xFFFFFFFD (−3) × 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mflo gives Md_Result=0xFFFFFFF1.
- div 0xFFFFFFF9 (−7) by 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 0x64 by 7 -> LO=0x0E, HI=0x02.
- div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 5 by 0 after mthi 0x1234 and mtlo 0x5678 -> Md_busy high 1 cycle; Md_done and Md_div_zero pulse together; HI=0x1234, LO=0x5678.
- Busy and reset interaction:
  - mthi 0xAAAA issued at iteration 10 of a mult -> ignored; final HI is the product.
  - reset_n low at iteration 20 -> immediately state IDLE, Md_busy=0, HI=LO=0, no Md_done.
